// File: rtl/second_timekeeper_if.sv
// Bundle of the signals exchanged between the second timekeeper and its
// surroundings.
//
// Port summary (as seen from the timekeeper, i.e. the slave modport):
//   enable, counter_in, sync_in, load_en, sec_in, min_in, hour_in  - inputs
//   cnt_rst, cnt_sync, pps, day_tick, sec, min, hour, phase_err,
//   load_err, running                                              - outputs
// The master modport is the mirror image, used by whatever drives the block.
interface second_timekeeper_if #(
    parameter int Nbits = 27
);
    logic             enable;
    logic [Nbits-1:0] counter_in;
    logic             sync_in;
    logic             load_en;
    logic [5:0]       sec_in;
    logic [5:0]       min_in;
    logic [4:0]       hour_in;
    logic             cnt_rst;
    logic             cnt_sync;
    logic             pps;
    logic             day_tick;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hour;
    logic [Nbits-1:0] phase_err;
    logic             load_err;
    logic             running;

    modport master (
        output enable, counter_in, sync_in, load_en, sec_in, min_in, hour_in,
        input  cnt_rst, cnt_sync, pps, day_tick, sec, min, hour, phase_err,
               load_err, running
    );

    modport slave (
        input  enable, counter_in, sync_in, load_en, sec_in, min_in, hour_in,
        output cnt_rst, cnt_sync, pps, day_tick, sec, min, hour, phase_err,
               load_err, running
    );
endinterface

// File: rtl/second_timekeeper.sv
// Second timekeeper: watches a free-running cycle counter, controls its two
// reset inputs so that one counter period equals one second, emits a
// one-cycle pps strobe and keeps a binary h:m:s time of day with load,
// PPS resync and phase-error capture.
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   reset  - synchronous active-high reset
//   bus    - second_timekeeper_if.slave (counter value, sync, load request
//            and load values in; counter controls, strobes, time of day,
//            phase error and run status out)
module second_timekeeper #(
    parameter int Nbits       = 27,
    parameter int nclks_total = 96830000
) (
    input  logic                 clk,
    input  logic                 reset,
    second_timekeeper_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [Nbits-1:0] LAST_CNT = Nbits'(nclks_total - 1);
    localparam logic [Nbits-1:0] HALF_CNT = Nbits'(nclks_total / 2);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             running_s;
    logic             sync_q_r;
    logic             wrap_s;
    logic             sync_edge_s;
    logic             sec_evt_s;
    logic             load_ok_s;
    logic             load_bad_s;
    logic             day_wrap_s;
    logic [5:0]       sec_nxt_s;
    logic [5:0]       min_nxt_s;
    logic [4:0]       hour_nxt_s;
    logic             pps_r;
    logic             day_tick_r;
    logic             load_err_r;
    logic [5:0]       sec_r;
    logic [5:0]       min_r;
    logic [4:0]       hour_r;
    logic [Nbits-1:0] phase_err_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: enable is a plain run/stop level
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (bus.enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        running_s = 1'b0;
        case (state_r)
            IDLE:    running_s = 1'b0;
            RUN:     running_s = 1'b1;
            default: running_s = 1'b0;
        endcase
    end

    // Counter control and second-event detection. The counter is held at 0
    // outside RUN; a late sync edge (second half of the period) counts as the
    // second boundary, an early one only realigns the counter. A sync edge on
    // the wrap cycle still yields a single event since both terms OR together.
    assign wrap_s      = running_s & (bus.counter_in == LAST_CNT);
    assign sync_edge_s = bus.sync_in & ~sync_q_r;
    assign sec_evt_s   = wrap_s | (running_s & sync_edge_s & (bus.counter_in >= HALF_CNT));
    assign bus.cnt_rst  = reset | ~running_s | wrap_s;
    assign bus.cnt_sync = running_s & sync_edge_s;

    // Load qualification: all three fields must be in range
    assign load_ok_s  = bus.load_en & (bus.sec_in <= 6'd59) & (bus.min_in <= 6'd59)
                        & (bus.hour_in <= 5'd23);
    assign load_bad_s = bus.load_en & ~load_ok_s;

    // Next time of day: a valid load overrides the increment
    always_comb begin
        sec_nxt_s  = sec_r;
        min_nxt_s  = min_r;
        hour_nxt_s = hour_r;
        day_wrap_s = 1'b0;
        if (load_ok_s) begin
            sec_nxt_s  = bus.sec_in;
            min_nxt_s  = bus.min_in;
            hour_nxt_s = bus.hour_in;
        end else if (sec_evt_s) begin
            if (sec_r == 6'd59) begin
                sec_nxt_s = 6'd0;
                if (min_r == 6'd59) begin
                    min_nxt_s = 6'd0;
                    if (hour_r == 5'd23) begin
                        hour_nxt_s = 5'd0;
                        day_wrap_s = 1'b1;
                    end else begin
                        hour_nxt_s = hour_r + 5'd1;
                    end
                end else begin
                    min_nxt_s = min_r + 6'd1;
                end
            end else begin
                sec_nxt_s = sec_r + 6'd1;
            end
        end else begin
            day_wrap_s = 1'b0;
        end
    end

    // Registered outputs, sync edge-detect flop and phase-error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q_r    <= 1'b0;
            pps_r       <= 1'b0;
            day_tick_r  <= 1'b0;
            load_err_r  <= 1'b0;
            sec_r       <= 6'd0;
            min_r       <= 6'd0;
            hour_r      <= 5'd0;
            phase_err_r <= '0;
        end else begin
            sync_q_r   <= bus.sync_in;
            pps_r      <= sec_evt_s;
            day_tick_r <= day_wrap_s;
            load_err_r <= load_bad_s;
            sec_r      <= sec_nxt_s;
            min_r      <= min_nxt_s;
            hour_r     <= hour_nxt_s;
            if (running_s & sync_edge_s) begin
                phase_err_r <= bus.counter_in;
            end else begin
                phase_err_r <= phase_err_r;
            end
        end
    end

    assign bus.pps       = pps_r;
    assign bus.day_tick  = day_tick_r;
    assign bus.load_err  = load_err_r;
    assign bus.sec       = sec_r;
    assign bus.min       = min_r;
    assign bus.hour      = hour_r;
    assign bus.phase_err = phase_err_r;
    assign bus.running   = running_s;
endmodule

// File: tb/tb_second_timekeeper.sv
// Directed bench for second_timekeeper with a 10-cycle second and a simple
// upstream cycle counter driven by the DUT's cnt_rst / cnt_sync outputs.
module tb_second_timekeeper;
    localparam int NB = 27;
    localparam int NCLK = 10;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    second_timekeeper_if #(.Nbits(NB)) bus ();

    second_timekeeper #(.Nbits(NB), .nclks_total(NCLK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream free-running cycle counter with two synchronous resets
    always_ff @(posedge clk) begin
        if (bus.cnt_rst | bus.cnt_sync) begin
            bus.counter_in <= '0;
        end else begin
            bus.counter_in <= bus.counter_in + 27'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_counter(input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (bus.counter_in == 27'(v)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("wait_counter_reached", 32'(hit), 32'd1);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        bus.load_en = 1'b1;
        bus.hour_in = 5'(h);
        bus.min_in  = 6'(m);
        bus.sec_in  = 6'(s);
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, 32'(bus.hour), 32'(h));
        check({tag, "_min"},  32'(bus.min),  32'(m));
        check({tag, "_sec"},  32'(bus.sec),  32'(s));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.sync_in  = 1'b0;
        bus.load_en  = 1'b0;
        bus.sec_in   = 6'd0;
        bus.min_in   = 6'd0;
        bus.hour_in  = 5'd0;

        // 1: reset state, then counting and pps period
        repeat (3) tick();
        check("rst_pps", 32'(bus.pps), 32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        check("rst_counter", 32'(bus.counter_in), 32'd0);
        check_time("rst", 0, 0, 0);
        check("rst_phase_err", 32'(bus.phase_err), 32'd0);
        reset      = 1'b0;
        bus.enable = 1'b1;
        tick();
        check("run_running", 32'(bus.running), 32'd1);
        check("run_counter0", 32'(bus.counter_in), 32'd0);
        check("run_cnt_rst0", 32'(bus.cnt_rst), 32'd0);
        repeat (9) tick();
        check("c9_counter", 32'(bus.counter_in), 32'd9);
        check("c9_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        check("c9_pps", 32'(bus.pps), 32'd0);
        tick();
        check("pps1", 32'(bus.pps), 32'd1);
        check("pps1_counter", 32'(bus.counter_in), 32'd0);
        check("pps1_sec", 32'(bus.sec), 32'd1);
        tick();
        check("pps1_low", 32'(bus.pps), 32'd0);
        repeat (8) tick();
        check("pre_pps2", 32'(bus.pps), 32'd0);
        tick();
        check("pps2", 32'(bus.pps), 32'd1);
        check("pps2_sec", 32'(bus.sec), 32'd2);

        // 2: day wrap
        do_load(23, 59, 59);
        check_time("ld235959", 23, 59, 59);
        wait_counter(9);
        tick();
        check("day_pps", 32'(bus.pps), 32'd1);
        check("day_tick", 32'(bus.day_tick), 32'd1);
        check_time("day_wrap", 0, 0, 0);
        tick();
        check("day_tick_low", 32'(bus.day_tick), 32'd0);

        // 3: late and early sync edges
        wait_counter(7);
        bus.sync_in = 1'b1;
        #1;
        check("late_cnt_sync", 32'(bus.cnt_sync), 32'd1);
        tick();
        bus.sync_in = 1'b0;
        check("late_sec", 32'(bus.sec), 32'd1);
        check("late_pps", 32'(bus.pps), 32'd1);
        check("late_phase", 32'(bus.phase_err), 32'd7);
        check("late_counter", 32'(bus.counter_in), 32'd0);
        wait_counter(2);
        bus.sync_in = 1'b1;
        #1;
        check("early_cnt_sync", 32'(bus.cnt_sync), 32'd1);
        tick();
        bus.sync_in = 1'b0;
        check("early_sec", 32'(bus.sec), 32'd1);
        check("early_pps", 32'(bus.pps), 32'd0);
        check("early_phase", 32'(bus.phase_err), 32'd2);
        check("early_counter", 32'(bus.counter_in), 32'd0);

        // 4: rejected load
        wait_counter(3);
        do_load(5, 10, 60);
        check("bad_load_err", 32'(bus.load_err), 32'd1);
        check_time("bad_load", 0, 0, 1);
        tick();
        check("bad_load_err_low", 32'(bus.load_err), 32'd0);

        // 5: load on wrap cycle, then sync coincident with wrap
        wait_counter(9);
        do_load(12, 0, 0);
        check_time("ld_wrap", 12, 0, 0);
        check("ld_wrap_pps", 32'(bus.pps), 32'd1);
        check("ld_wrap_err", 32'(bus.load_err), 32'd0);
        wait_counter(9);
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
        check("sw_pps", 32'(bus.pps), 32'd1);
        check("sw_sec", 32'(bus.sec), 32'd1);
        check("sw_phase", 32'(bus.phase_err), 32'd9);
        check("sw_counter", 32'(bus.counter_in), 32'd0);
        tick();
        check("sw_pps_low", 32'(bus.pps), 32'd0);
        check("sw_sec_hold", 32'(bus.sec), 32'd1);

        // 6: reset mid-run, then stop via enable
        wait_counter(2);
        do_load(3, 4, 5);
        check_time("ld030405", 3, 4, 5);
        wait_counter(5);
        reset = 1'b1;
        #1;
        check("mid_rst_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        tick();
        check("mid_rst_running", 32'(bus.running), 32'd0);
        check("mid_rst_counter", 32'(bus.counter_in), 32'd0);
        check_time("mid_rst", 0, 0, 0);
        check("mid_rst_phase", 32'(bus.phase_err), 32'd0);
        check("mid_rst_pps", 32'(bus.pps), 32'd0);
        tick();
        check("mid_rst_counter_held", 32'(bus.counter_in), 32'd0);
        reset = 1'b0;
        tick();
        check("rerun_running", 32'(bus.running), 32'd1);
        do_load(1, 2, 3);
        bus.enable = 1'b0;
        tick();
        check("stop_running", 32'(bus.running), 32'd0);
        check("stop_cnt_rst", 32'(bus.cnt_rst), 32'd1);
        bus.sync_in = 1'b1;
        #1;
        check("idle_cnt_sync", 32'(bus.cnt_sync), 32'd0);
        repeat (15) tick();
        bus.sync_in = 1'b0;
        check_time("stop_hold", 1, 2, 3);
        check("stop_counter", 32'(bus.counter_in), 32'd0);
        check("stop_pps", 32'(bus.pps), 32'd0);
        check("idle_phase", 32'(bus.phase_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
